ipsxe_floating_point_apm_rne_arb_v1_0: RTL and testbench
========================================================

IPSXE_FLOATING_POINT_APM_RNE_ARB_V1_0 -- requirements
Module: ipsxe_floating_point_apm_rne_arb_v1_0

Interface
REQ-001 Parameter MAN_WIDTH, default 52, mantissa width excluding the hidden bit.
REQ-002 Parameter RNE, default 2, guard bits.
REQ-003 Parameter RNE1, default 49, extra product bits.
REQ-004 Parameter RNE2, default 44, low bits discarded by rounding; bit RNE2-1 is the round bit.
REQ-005 Parameter LATENCY_CONFIG, default 1, user latency setting.
REQ-006 Parameter PIPE_STAGE_NUM_MAX, default 1, pipeline depth reference.
REQ-007 Derived IN_W = ((MAN_WIDTH+1)+RNE+RNE1)/2+RNE2-9 (87 at defaults); OUT_W = ((MAN_WIDTH+1)+RNE+RNE1)/2-9 (43 at defaults); APM_LAT = 1 if LATENCY_CONFIG >= PIPE_STAGE_NUM_MAX-5, else 0.
REQ-008 i_clk  input  1  sole clock, rising edge.
REQ-009 i_rst  input  1  reset, synchronous, active-high.
REQ-010 i_req0_valid / i_req1_valid  input  1 each  requester n offers an operand.
REQ-011 i_req0_data / i_req1_data  input  IN_W each  operand (unrounded product, low 9 zero bits removed).
REQ-012 o_req0_ready / o_req1_ready  output  1 each  operand accepted this cycle when valid&ready.
REQ-013 o_res0_valid / o_res1_valid  output  1 each  rounded result held for requester n.
REQ-014 o_res0_data / o_res1_data  output  OUT_W each  rounded result.
REQ-015 i_res0_ready / i_res1_ready  input  1 each  consumer n takes the result when valid&ready.
REQ-016 o_busy  output  1  any operation in flight or any result held.

Function
REQ-017 The block SHALL share one rounding APM between the two requesters; result = data[IN_W-1:RNE2] + data[RNE2-1], modulo 2^OUT_W (carry-out discarded).
REQ-018 Requester n SHALL be eligible when i_reqn_valid=1, no op for n is in flight, and o_resn_valid=0 or i_resn_ready=1 in that cycle.
REQ-019 Grant: at most one requester per cycle; a sole eligible requester wins; on a tie, the requester not granted last wins (round-robin); the last-grant pointer updates only on a grant.
REQ-020 o_reqn_ready SHALL be 1 exactly in the cycle requester n is granted; it is combinational from the valids, state and i_resn_ready.
REQ-021 A tag pipeline of depth APM_LAT SHALL carry {valid, requester id} alongside the APM; the result register for the tagged requester loads APM_LAT+1 cycles after the grant edge (APM_LAT=0: loads on the next edge).
REQ-022 o_resn_valid SHALL set on load and clear on valid&ready with no simultaneous load; simultaneous pop and load SHALL keep valid=1 with new data.
REQ-023 o_resn_data SHALL stay stable while o_resn_valid=1 and i_resn_ready=0.
REQ-024 Sustained throughput SHALL be one op per cycle when both requesters alternate and results are drained; a single requester gets one op per APM_LAT+1 cycles.
REQ-025 A requester dropping i_reqn_valid without a grant SHALL leave the arbiter state unchanged.

Reset
REQ-026 While i_rst=1 the block SHALL drive o_reqn_ready=0, o_resn_valid=0, o_resn_data=0 and o_busy=0, and SHALL clear all tag valids; last-grant resets to requester 1, so requester 0 wins the first tie.
REQ-027 Reset asserted mid-operation SHALL discard in-flight ops; no result appears after reset release for operands accepted before it.

Structure
REQ-028 IN_W, OUT_W and APM_LAT derivations SHALL reside in the shared floating-point constants include, for reuse by the other APM rounding wrappers.
REQ-029 The design SHALL contain one GTP_APM_E2 configured as Z + X*1: Y=18'd1, Z=operand upper field, X=round bit, X/Z registers = APM_LAT, all other registers off.
REQ-030 A sub-module ipsxe_floating_point_rr_arb2_v1_0 SHALL implement the 2-way round-robin grant and the last-grant pointer.

Verification
REQ-031 Req0 only, data upper field 0x1234, bit RNE2-1=1 -> o_res0_data=0x1235 exactly APM_LAT+1 cycles after grant; o_res1_valid stays 0.
REQ-032 Both valid every cycle, results always drained -> grants alternate 0,1,0,1 starting with 0 after reset; one result per cycle after fill.
REQ-033 Upper field all ones, round bit 1 -> result 0 (wrap); round bit 0 -> result all ones.
REQ-034 i_res0_ready=0 with o_res0_valid=1 -> req0 is never granted, data is held stable, req1 proceeds; raising ready re-enables req0 in the same cycle.
REQ-035 i_rst pulsed one cycle after a grant -> no o_resn_valid afterwards; the next tie is granted to requester 0.
REQ-036 Run REQ-031..035 with LATENCY_CONFIG set for APM_LAT=0 and APM_LAT=1; compare against a behavioural scoreboard of REQ-017.

Source files
------------

// File: rtl/ipsxe_floating_point_apm_rne_arb_v1_0_pkg.sv
// Shared constants for the APM rounding wrappers.
// Width and latency derivations live here so every wrapper agrees on them.
package ipsxe_floating_point_apm_rne_arb_v1_0_pkg;

    localparam logic [17:0] APM_Y_ONE = 18'd1;

    typedef enum logic {
        REQ_0 = 1'b0,
        REQ_1 = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    vld;
        req_id_e id;
    } apm_tag_t;

    function automatic int calc_in_w(
        input int man_w,
        input int rne,
        input int rne1,
        input int rne2
    );
        return ((man_w + 1) + rne + rne1) / 2 + rne2 - 9;
    endfunction

    function automatic int calc_out_w(
        input int man_w,
        input int rne,
        input int rne1
    );
        return ((man_w + 1) + rne + rne1) / 2 - 9;
    endfunction

    function automatic int calc_apm_lat(
        input int lat_cfg,
        input int pipe_max
    );
        return (lat_cfg >= pipe_max - 5) ? 1 : 0;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_apm_rne_arb_v1_0_if.sv
// Requester/result handshake bundle of the shared APM rounding arbiter.
// The slave side is the arbiter, the master side drives operands and drains results.
interface ipsxe_floating_point_apm_rne_arb_v1_0_if #(
    parameter int IN_W  = 87,
    parameter int OUT_W = 43
);

    logic             i_req0_valid;
    logic             i_req1_valid;
    logic [IN_W-1:0]  i_req0_data;
    logic [IN_W-1:0]  i_req1_data;
    logic             o_req0_ready;
    logic             o_req1_ready;
    logic             o_res0_valid;
    logic             o_res1_valid;
    logic [OUT_W-1:0] o_res0_data;
    logic [OUT_W-1:0] o_res1_data;
    logic             i_res0_ready;
    logic             i_res1_ready;
    logic             o_busy;

    modport slave (
        input  i_req0_valid,
        input  i_req1_valid,
        input  i_req0_data,
        input  i_req1_data,
        output o_req0_ready,
        output o_req1_ready,
        output o_res0_valid,
        output o_res1_valid,
        output o_res0_data,
        output o_res1_data,
        input  i_res0_ready,
        input  i_res1_ready,
        output o_busy
    );

    modport master (
        output i_req0_valid,
        output i_req1_valid,
        output i_req0_data,
        output i_req1_data,
        input  o_req0_ready,
        input  o_req1_ready,
        input  o_res0_valid,
        input  o_res1_valid,
        input  o_res0_data,
        input  o_res1_data,
        output i_res0_ready,
        output i_res1_ready,
        input  o_busy
    );

endinterface

// File: rtl/ipsxe_floating_point_rr_arb2_v1_0.sv
// Two-way round-robin grant with a last-grant pointer.
// The pointer only moves on a grant, so withdrawn requests leave it untouched.
module ipsxe_floating_point_rr_arb2_v1_0
    import ipsxe_floating_point_apm_rne_arb_v1_0_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_elig,
    output logic [1:0] o_gnt
);

    req_id_e last_q;
    req_id_e last_d;

    always_comb begin
        o_gnt  = 2'b00;
        last_d = last_q;
        unique case (i_elig)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (last_q == REQ_1) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
        if (o_gnt[0]) begin
            last_d = REQ_0;
        end else if (o_gnt[1]) begin
            last_d = REQ_1;
        end
    end

    // Pointer starts at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= REQ_1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ipsxe_floating_point_apm_rne_arb_v1_0.sv
// Two requesters share one rounding APM computing Z + X*1 (upper field + round bit).
// A {valid, id} tag rides alongside the APM to steer each result to its owner.
module ipsxe_floating_point_apm_rne_arb_v1_0
    import ipsxe_floating_point_apm_rne_arb_v1_0_pkg::*;
#(
    parameter int MAN_WIDTH          = 52,
    parameter int RNE                = 2,
    parameter int RNE1               = 49,
    parameter int RNE2               = 44,
    parameter int LATENCY_CONFIG     = 1,
    parameter int PIPE_STAGE_NUM_MAX = 1
) (
    input logic i_clk,
    input logic i_rst,
    ipsxe_floating_point_apm_rne_arb_v1_0_if.slave bus
);

    localparam int IN_W    = calc_in_w(MAN_WIDTH, RNE, RNE1, RNE2);
    localparam int OUT_W   = calc_out_w(MAN_WIDTH, RNE, RNE1);
    localparam int APM_LAT = calc_apm_lat(LATENCY_CONFIG, PIPE_STAGE_NUM_MAX);

    logic [1:0]       req_vld;
    logic [1:0]       res_rdy;
    logic [1:0]       elig;
    logic [1:0]       gnt;
    logic [1:0]       inflight;
    logic [1:0]       load;
    logic [1:0]       pop;
    logic [1:0]       res_vld;
    logic [OUT_W-1:0] res_dat [2];

    logic [IN_W-1:0]  sel_dat;
    logic [RNE2-2:0]  low_unused;
    apm_tag_t         tag_d;
    apm_tag_t         tag_s;
    logic [OUT_W-1:0] z_d;
    logic [OUT_W-1:0] z_s;
    logic             x_d;
    logic             x_s;
    logic [OUT_W-1:0] apm_p;

    assign req_vld = {bus.i_req1_valid, bus.i_req0_valid};
    assign res_rdy = {bus.i_res1_ready, bus.i_res0_ready};

    // A held result must be drained this cycle before its owner may issue again.
    assign elig = req_vld & ~inflight & (~res_vld | res_rdy) & {2{~i_rst}};

    ipsxe_floating_point_rr_arb2_v1_0 u_arb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_elig (elig),
        .o_gnt  (gnt)
    );

    always_comb begin
        tag_d     = '0;
        tag_d.vld = |gnt;
        tag_d.id  = gnt[1] ? REQ_1 : REQ_0;
        sel_dat   = gnt[1] ? bus.i_req1_data : bus.i_req0_data;
        z_d       = sel_dat[IN_W-1:RNE2];
        x_d       = sel_dat[RNE2-1];
    end

    // Bits below the round bit never influence the rounded result.
    assign low_unused = sel_dat[RNE2-2:0];

    generate
        if (APM_LAT != 0) begin : g_apm_reg
            apm_tag_t         tag_q;
            logic [OUT_W-1:0] z_q;
            logic             x_q;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    tag_q <= '0;
                    z_q   <= '0;
                    x_q   <= 1'b0;
                end else begin
                    tag_q <= tag_d;
                    z_q   <= z_d;
                    x_q   <= x_d;
                end
            end

            assign tag_s    = tag_q;
            assign z_s      = z_q;
            assign x_s      = x_q;
            assign inflight = {
                tag_q.vld & (tag_q.id == REQ_1),
                tag_q.vld & (tag_q.id == REQ_0)
            };
        end else begin : g_apm_comb
            assign tag_s    = tag_d;
            assign z_s      = z_d;
            assign x_s      = x_d;
            assign inflight = 2'b00;
        end
    endgenerate

    // APM post-adder: carry out of the upper field is dropped.
    assign apm_p = z_s + OUT_W'(x_s) * OUT_W'(APM_Y_ONE);

    for (genvar n = 0; n < 2; n++) begin : g_res
        logic             vld_q;
        logic             vld_d;
        logic [OUT_W-1:0] dat_q;
        logic [OUT_W-1:0] dat_d;

        assign load[n] = tag_s.vld & (tag_s.id == ((n == 1) ? REQ_1 : REQ_0));
        assign pop[n]  = vld_q & res_rdy[n];

        always_comb begin
            vld_d = vld_q;
            dat_d = dat_q;
            if (load[n]) begin
                vld_d = 1'b1;
                dat_d = apm_p;
            end else if (pop[n]) begin
                vld_d = 1'b0;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign res_vld[n] = vld_q;
        assign res_dat[n] = dat_q;
    end

    assign bus.o_req0_ready = gnt[0];
    assign bus.o_req1_ready = gnt[1];
    assign bus.o_res0_valid = res_vld[0] & ~i_rst;
    assign bus.o_res1_valid = res_vld[1] & ~i_rst;
    assign bus.o_res0_data  = i_rst ? '0 : res_dat[0];
    assign bus.o_res1_data  = i_rst ? '0 : res_dat[1];
    assign bus.o_busy       = ~i_rst & ((|res_vld) | (|inflight));

endmodule

// File: tb/tb_ipsxe_floating_point_apm_rne_arb_v1_0.sv
// Bench for the shared APM rounding arbiter: APM_LAT=0 and APM_LAT=1
// instances see identical stimulus, each checked against its own reference model.
module tb_ipsxe_floating_point_apm_rne_arb_v1_0;

    localparam int IN_W  = 87;
    localparam int OUT_W = 43;
    localparam int RNE2  = 44;
    localparam logic [OUT_W-1:0] ONES = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            req_v [2];
    logic            res_r [2];
    logic [IN_W-1:0] req_d [2];

    logic             o_rdy  [2][2];
    logic             o_rv   [2][2];
    logic [OUT_W-1:0] o_rd   [2][2];
    logic             o_busy [2];

    ipsxe_floating_point_apm_rne_arb_v1_0_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus [2] ();

    for (genvar k = 0; k < 2; k++) begin : g_bus
        assign bus[k].i_req0_valid = req_v[0];
        assign bus[k].i_req1_valid = req_v[1];
        assign bus[k].i_req0_data  = req_d[0];
        assign bus[k].i_req1_data  = req_d[1];
        assign bus[k].i_res0_ready = res_r[0];
        assign bus[k].i_res1_ready = res_r[1];
        assign o_rdy[k][0]  = bus[k].o_req0_ready;
        assign o_rdy[k][1]  = bus[k].o_req1_ready;
        assign o_rv[k][0]   = bus[k].o_res0_valid;
        assign o_rv[k][1]   = bus[k].o_res1_valid;
        assign o_rd[k][0]   = bus[k].o_res0_data;
        assign o_rd[k][1]   = bus[k].o_res1_data;
        assign o_busy[k]    = bus[k].o_busy;
    end

    // 1 >= 10-5 is false -> APM_LAT=0
    ipsxe_floating_point_apm_rne_arb_v1_0 #(
        .LATENCY_CONFIG     (1),
        .PIPE_STAGE_NUM_MAX (10)
    ) u_dut_lat0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus[0])
    );

    // 1 >= 1-5 is true -> APM_LAT=1
    ipsxe_floating_point_apm_rne_arb_v1_0 #(
        .LATENCY_CONFIG     (1),
        .PIPE_STAGE_NUM_MAX (1)
    ) u_dut_lat1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus[1])
    );

    typedef struct {
        int               k;
        int               id;
        logic [OUT_W-1:0] val;
        int               due;
    } op_t;

    op_t              fifo [$];
    int               lat_of [2];
    int               m_last [2];
    logic             m_rv [2][2];
    logic [OUT_W-1:0] m_rd [2][2];
    logic [OUT_W-1:0] held [2];
    int               cyc   = 0;
    int               total = 0;
    int               bad   = 0;

    function automatic logic [OUT_W-1:0] ref_round(input logic [IN_W-1:0] d);
        logic [IN_W-1:0] up;
        logic [IN_W-1:0] rb;
        up = d >> RNE2;
        rb = (d >> (RNE2 - 1)) & IN_W'(1);
        return OUT_W'(up + rb);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Arbitration rules applied directly: eligibility, round-robin tie, delayed delivery.
    task automatic model_cycle(input int k);
        bit  infl [2];
        bit  el [2];
        int  g;
        op_t op;
        infl[0] = 1'b0;
        infl[1] = 1'b0;
        foreach (fifo[i]) begin
            if (fifo[i].k == k) begin
                if (fifo[i].id == 0) infl[0] = 1'b1;
                else infl[1] = 1'b1;
            end
        end
        for (int n = 0; n < 2; n++) begin
            el[n] = !rst && req_v[n] && !infl[n] && (!m_rv[k][n] || res_r[n]);
        end
        g = -1;
        if (el[0] && el[1]) g = (m_last[k] == 1) ? 0 : 1;
        else if (el[0]) g = 0;
        else if (el[1]) g = 1;
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("lat%0d rdy%0d c%0d", lat_of[k], n, cyc),
                64'(o_rdy[k][n]), 64'(g == n));
            chk($sformatf("lat%0d rv%0d c%0d", lat_of[k], n, cyc),
                64'(o_rv[k][n]), 64'(!rst && m_rv[k][n]));
            chk($sformatf("lat%0d rd%0d c%0d", lat_of[k], n, cyc),
                64'(o_rd[k][n]), rst ? 64'(0) : 64'(m_rd[k][n]));
        end
        chk($sformatf("lat%0d busy c%0d", lat_of[k], cyc), 64'(o_busy[k]),
            64'(!rst && (m_rv[k][0] || m_rv[k][1] || infl[0] || infl[1])));
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                m_rv[k][n] = 1'b0;
                m_rd[k][n] = '0;
            end
            m_last[k] = 1;
            for (int i = fifo.size() - 1; i >= 0; i--) begin
                if (fifo[i].k == k) fifo.delete(i);
            end
            return;
        end
        for (int n = 0; n < 2; n++) begin
            if (m_rv[k][n] && res_r[n]) m_rv[k][n] = 1'b0;
        end
        if (g >= 0) begin
            op.k   = k;
            op.id  = g;
            op.val = ref_round(req_d[g]);
            op.due = cyc + lat_of[k];
            fifo.push_back(op);
            m_last[k] = g;
        end
        for (int i = fifo.size() - 1; i >= 0; i--) begin
            if (fifo[i].k == k && fifo[i].due == cyc) begin
                m_rv[k][fifo[i].id] = 1'b1;
                m_rd[k][fifo[i].id] = fifo[i].val;
                fifo.delete(i);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle(0);
        model_cycle(1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v0, input logic v1, input logic r0, input logic r1);
        req_v[0] = v0;
        req_v[1] = v1;
        res_r[0] = r0;
        res_r[1] = r1;
    endtask

    task automatic rand_data();
        req_d[0] = IN_W'({$urandom(), $urandom(), $urandom()});
        req_d[1] = IN_W'({$urandom(), $urandom(), $urandom()});
    endtask

    // Lone requester n: result lands one edge after grant at lat0, two at lat1.
    task automatic single(input int n, input logic [IN_W-1:0] d, input logic [OUT_W-1:0] want);
        set_in(n == 0, n == 1, 1'b1, 1'b1);
        req_d[n] = d;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("single%0d lat%0d grant", n, k), 64'(o_rdy[k][n]), 64'd1);
        end
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk($sformatf("single%0d lat0 rv", n), 64'(o_rv[0][n]), 64'd1);
        chk($sformatf("single%0d lat0 rd", n), 64'(o_rd[0][n]), 64'(want));
        chk($sformatf("single%0d lat0 other rv", n), 64'(o_rv[0][1-n]), 64'd0);
        chk($sformatf("single%0d lat1 early rv", n), 64'(o_rv[1][n]), 64'd0);
        step();
        #1;
        chk($sformatf("single%0d lat1 rv", n), 64'(o_rv[1][n]), 64'd1);
        chk($sformatf("single%0d lat1 rd", n), 64'(o_rd[1][n]), 64'(want));
        chk($sformatf("single%0d lat1 other rv", n), 64'(o_rv[1][1-n]), 64'd0);
        step();
    endtask

    initial begin
        lat_of[0] = 0;
        lat_of[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1;
            for (int n = 0; n < 2; n++) begin
                m_rv[k][n] = 1'b0;
                m_rd[k][n] = '0;
            end
        end
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        req_d[0] = '0;
        req_d[1] = '0;
        repeat (2) step();

        // requests during reset must not be granted
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        rand_data();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst rdy0", 64'(o_rdy[k][0]), 64'd0);
            chk("rst rdy1", 64'(o_rdy[k][1]), 64'd0);
            chk("rst busy", 64'(o_busy[k]), 64'd0);
            chk("rst rd0", 64'(o_rd[k][0]), 64'd0);
        end
        repeat (2) step();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        step();

        single(0, {43'h1234, 1'b1, 43'h0}, 43'h1235);
        single(0, {ONES, 1'b1, 43'h0}, 43'h0);
        single(1, {ONES, 1'b0, 43'h7ff}, ONES);
        rand_data();
        single(1, req_d[1], ref_round(req_d[1]));

        // both requesting every cycle, results drained
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        rand_data();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("first tie rdy0", 64'(o_rdy[k][0]), 64'd1);
            chk("first tie rdy1", 64'(o_rdy[k][1]), 64'd0);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            rand_data();
            #1;
            if (i >= 2) begin
                for (int k = 0; k < 2; k++) begin
                    chk("alt one grant", 64'(o_rdy[k][0] ^ o_rdy[k][1]), 64'd1);
                    chk("one result", 64'(o_rv[k][0] ^ o_rv[k][1]), 64'd1);
                end
            end
        end

        // consumer 0 stalls: req0 blocked, data held, req1 continues
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) begin
            step();
            rand_data();
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("stall rv0", 64'(o_rv[k][0]), 64'd1);
            held[k] = o_rd[k][0];
        end
        for (int i = 0; i < 10; i++) begin
            step();
            rand_data();
            #1;
            for (int k = 0; k < 2; k++) begin
                chk("stall rdy0", 64'(o_rdy[k][0]), 64'd0);
                chk("stall hold", 64'(o_rd[k][0]), 64'(held[k]));
            end
        end
        res_r[0] = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("unstall rdy0", 64'(o_rdy[k][0]), 64'd1);
        end
        step();

        // reset one cycle after a grant discards the op
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        rand_data();
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            #1;
            for (int k = 0; k < 2; k++) begin
                chk("post rst rv0", 64'(o_rv[k][0]), 64'd0);
                chk("post rst rv1", 64'(o_rv[k][1]), 64'd0);
            end
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        rand_data();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("post rst tie", 64'(o_rdy[k][0]), 64'd1);
        end
        step();

        for (int i = 0; i < 400; i++) begin
            req_v[0] = 1'($urandom_range(0, 1));
            req_v[1] = 1'($urandom_range(0, 1));
            res_r[0] = ($urandom_range(0, 3) != 0);
            res_r[1] = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            rand_data();
            step();
        end

        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
